// File: rtl/irq_router.sv
// irq_router: routes tile INT/NMI requests to CPU INT/NMI pins via a config table.
// Define IRQ_ROUTER_STATUS_EN to add a read-only status byte after the NMI entries.
module irq_router #(
  parameter int NUM_SLOTS = 3,
  parameter int NUM_CPU_INT = 2,
  parameter int NUM_CPU_NMI = 1,
  parameter int NUM_TILE_INT_CH = 2,
  parameter int CFG_ADDR_WIDTH = 8,
  localparam int SLOT_IDX_WIDTH = (NUM_SLOTS <= 1) ? 1 : $clog2(NUM_SLOTS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_clk,
  input  logic [NUM_SLOTS*NUM_TILE_INT_CH-1:0]  tile_int_req,
  input  logic [NUM_SLOTS-1:0]                  tile_nmi_req,
  input  logic                                  irq_ack,
  output logic [NUM_CPU_INT-1:0]                cpu_int,
  output logic [NUM_CPU_NMI-1:0]                cpu_nmi,
  output logic [NUM_SLOTS-1:0]                  slot_ack,
  output logic                                  irq_int_active,
  output logic [SLOT_IDX_WIDTH-1:0]             irq_int_slot,
  input  logic                                  cfg_wr_en,
  input  logic                                  cfg_rd_en,
  input  logic [CFG_ADDR_WIDTH-1:0]             cfg_addr,
  input  logic [7:0]                            cfg_wdata,
  output logic [7:0]                            cfg_rdata
);

  localparam int NUM_INT = NUM_SLOTS * NUM_TILE_INT_CH;
  localparam int NUM_ENT = NUM_INT + NUM_SLOTS;
  localparam int SRC_W = (NUM_ENT <= 1) ? 1 : $clog2(NUM_ENT);

  logic [NUM_ENT-1:0] ent_en;
  logic [3:0]         ent_idx [NUM_ENT];
  logic [NUM_ENT-1:0] elig;

  logic                      act_valid;
  logic                      act_nmi;
  logic [SRC_W-1:0]          act_src;
  logic [SLOT_IDX_WIDTH-1:0] act_slot;
  logic [3:0]                act_idx;

  logic                      pick_valid;
  logic                      pick_nmi;
  logic [SRC_W-1:0]          pick_src;
  logic [SLOT_IDX_WIDTH-1:0] pick_slot;
  logic                      hold;

  logic unused_ok;
  assign unused_ok = ^{cfg_clk, cfg_wdata[6:4]};

  assign elig = {tile_nmi_req, tile_int_req} & ent_en;
  assign hold = act_valid && elig[act_src];

  // Scan low priority first so the last hit (lowest NMI, else lowest INT) wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_nmi   = 1'b0;
    pick_src   = '0;
    pick_slot  = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick_valid = 1'b1;
        pick_nmi   = 1'b0;
        pick_src   = SRC_W'(i);
        pick_slot  = SLOT_IDX_WIDTH'(i / NUM_TILE_INT_CH);
      end
    end
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (elig[NUM_INT+s]) begin
        pick_valid = 1'b1;
        pick_nmi   = 1'b1;
        pick_src   = SRC_W'(NUM_INT + s);
        pick_slot  = SLOT_IDX_WIDTH'(s);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_valid <= 1'b0;
      act_nmi   <= 1'b0;
      act_src   <= '0;
      act_slot  <= '0;
      act_idx   <= 4'd0;
    end else if (!hold) begin
      act_valid <= pick_valid;
      act_nmi   <= pick_nmi;
      act_src   <= pick_src;
      act_slot  <= pick_slot;
      act_idx   <= pick_valid ? ent_idx[pick_src] : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_en <= '0;
      for (int i = 0; i < NUM_ENT; i++) begin
        ent_idx[i] <= 4'd0;
      end
    end else if (cfg_wr_en) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        if (cfg_addr == CFG_ADDR_WIDTH'(i)) begin
          ent_en[i]  <= cfg_wdata[7];
          ent_idx[i] <= cfg_wdata[3:0];
        end
      end
    end
  end

  always_comb begin
    cpu_int = '0;
    cpu_nmi = '0;
    for (int p = 0; p < NUM_CPU_INT; p++) begin
      cpu_int[p] = act_valid && !act_nmi && (act_idx == 4'(p));
    end
    for (int p = 0; p < NUM_CPU_NMI; p++) begin
      cpu_nmi[p] = act_valid && act_nmi && (act_idx == 4'(p));
    end
  end

  always_comb begin
    slot_ack = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      slot_ack[s] = act_valid && irq_ack &&
                    (act_slot == SLOT_IDX_WIDTH'(s));
    end
  end

  assign irq_int_active = act_valid && !act_nmi;
  assign irq_int_slot   = irq_int_active ? act_slot : '0;

  always_comb begin
    cfg_rdata = 8'h00;
    if (cfg_rd_en) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        if (cfg_addr == CFG_ADDR_WIDTH'(i)) begin
          cfg_rdata = {ent_en[i], 3'b000, ent_idx[i]};
        end
      end
`ifdef IRQ_ROUTER_STATUS_EN
      if (cfg_addr == CFG_ADDR_WIDTH'(NUM_ENT)) begin
        cfg_rdata = {act_valid, act_nmi, 2'b00, 4'(act_slot)};
      end
`endif
    end
  end

endmodule

// File: tb/tb_irq_router.sv
// tb_irq_router: directed stimulus, per-cycle compare against a table/queue model
// plus literal expectations for the documented routing scenarios.
module tb_irq_router;

  localparam int NS  = 3;
  localparam int NCH = 2;
  localparam int NI  = NS * NCH;
  localparam int NE  = NI + NS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] tile_int_req = '0;
  logic [2:0] tile_nmi_req = '0;
  logic       irq_ack = 1'b0;
  logic [1:0] cpu_int;
  logic [0:0] cpu_nmi;
  logic [2:0] slot_ack;
  logic       irq_int_active;
  logic [1:0] irq_int_slot;
  logic       cfg_wr_en = 1'b0;
  logic       cfg_rd_en = 1'b0;
  logic [7:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [7:0] cfg_rdata;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  irq_router dut (
    .clk(clk), .rst_n(rst_n), .cfg_clk(clk),
    .tile_int_req(tile_int_req), .tile_nmi_req(tile_nmi_req),
    .irq_ack(irq_ack), .cpu_int(cpu_int), .cpu_nmi(cpu_nmi),
    .slot_ack(slot_ack), .irq_int_active(irq_int_active),
    .irq_int_slot(irq_int_slot), .cfg_wr_en(cfg_wr_en),
    .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );

  // model: table as plain arrays, active source as an index (-1 = none)
  int m_en [NE];
  int m_idx [NE];
  int m_act = -1;
  int m_aidx = 0;

  function automatic bit src_req(int src);
    if (src < NI) return tile_int_req[src];
    return tile_nmi_req[src-NI];
  endfunction

  always @(posedge clk) begin
    int nxt;
    bit keep;
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) begin
        m_en[i] <= 0;
        m_idx[i] <= 0;
      end
      m_act <= -1;
      m_aidx <= 0;
    end else begin
      keep = (m_act >= 0) && src_req(m_act) && (m_en[m_act] != 0);
      nxt = -1;
      if (keep) nxt = m_act;
      for (int s = 0; s < NS; s++)
        if (!keep && nxt < 0 && tile_nmi_req[s] && m_en[NI+s] != 0) nxt = NI + s;
      for (int i = 0; i < NI; i++)
        if (!keep && nxt < 0 && tile_int_req[i] && m_en[i] != 0) nxt = i;
      if (!keep) m_aidx <= (nxt >= 0) ? m_idx[nxt] : 0;
      m_act <= nxt;
      if (cfg_wr_en && cfg_addr < NE) begin
        m_en[cfg_addr] <= cfg_wdata[7] ? 1 : 0;
        m_idx[cfg_addr] <= int'(cfg_wdata[3:0]);
      end
    end
  end

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int e_int, e_nmi, e_ack, e_ia, e_is, e_rd, slot;
    if (chk_on) begin
      e_int = 0; e_nmi = 0; e_ack = 0; e_ia = 0; e_is = 0; e_rd = 0;
      slot = (m_act < NI) ? m_act / NCH : m_act - NI;
      if (m_act >= 0 && m_act < NI) begin
        if (m_aidx < 2) e_int = 1 << m_aidx;
        e_ia = 1;
        e_is = slot;
      end
      if (m_act >= NI && m_aidx < 1) e_nmi = 1;
      if (m_act >= 0 && irq_ack) e_ack = 1 << slot;
      if (cfg_rd_en && cfg_addr < NE)
        e_rd = (m_en[cfg_addr] << 7) | m_idx[cfg_addr];
`ifdef IRQ_ROUTER_STATUS_EN
      if (cfg_rd_en && cfg_addr == NE && m_act >= 0)
        e_rd = 8'h80 | ((m_act >= NI) ? 8'h40 : 8'h00) | slot;
`endif
      chk("m_cpu_int", int'(cpu_int), e_int);
      chk("m_cpu_nmi", int'(cpu_nmi), e_nmi);
      chk("m_slot_ack", int'(slot_ack), e_ack);
      chk("m_int_active", int'(irq_int_active), e_ia);
      chk("m_int_slot", int'(irq_int_slot), e_is);
      chk("m_rdata", int'(cfg_rdata), e_rd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cfg_wr_en = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    cyc();
    cfg_wr_en = 1'b0;
  endtask

  initial begin
    cyc();
    chk_on = 1'b1;
    cyc();
    look();
    chk("rst_cpu_int", int'(cpu_int), 0);
    chk("rst_slot_ack", int'(slot_ack), 0);
    cyc();
    rst_n = 1'b1;

    // basic route and config readback
    wr(8'd0, 8'h80);
    wr(8'd1, 8'hF5);
    wr(8'h20, 8'h81);
    cfg_rd_en = 1'b1;
    cfg_addr = 8'd1;
    look();
    chk("rd_mask", int'(cfg_rdata), 8'h85);
    cyc();
    cfg_addr = 8'h20;
    look();
    chk("rd_unmapped", int'(cfg_rdata), 0);
    cyc();
    cfg_rd_en = 1'b0;
    tile_int_req = 6'b000001;
    cyc();
    look();
    chk("route_int0", int'(cpu_int), 2'b01);
    cyc();
    tile_int_req = '0;
    cyc();
    look();
    chk("drop_int0", int'(cpu_int), 2'b00);

    // no queuing of a short pulse
    wr(8'd2, 8'h81);
    tile_int_req = 6'b000001;
    cyc();
    tile_int_req = 6'b000101;
    cyc();
    tile_int_req = 6'b000000;
    cyc();
    look();
    chk("no_queue", int'(cpu_int), 2'b00);

    // NMI beats INT
    wr(8'd7, 8'h80);
    tile_int_req = 6'b000001;
    tile_nmi_req = 3'b010;
    cyc();
    look();
    chk("nmi_win_nmi", int'(cpu_nmi), 1);
    chk("nmi_win_int", int'(cpu_int), 0);
    cyc();
    irq_ack = 1'b1;
    look();
    chk("nmi_ack", int'(slot_ack), 3'b010);
    chk("nmi_int_active", int'(irq_int_active), 0);
    cyc();
    irq_ack = 1'b0;
    tile_nmi_req = '0;
    cyc();
    look();
    chk("nmi_handover", int'(cpu_int), 2'b01);

    // INT priority by index, zero-idle handover
    cyc();
    tile_int_req = '0;
    cyc();
    tile_int_req = 6'b000101;
    cyc();
    look();
    chk("prio_low", int'(cpu_int), 2'b01);
    cyc();
    tile_int_req = 6'b000100;
    cyc();
    look();
    chk("prio_next", int'(cpu_int), 2'b10);
    chk("prio_slot", int'(irq_int_slot), 1);
    cyc();
    tile_int_req = '0;
    cyc();

    // ack steering
    tile_int_req = 6'b000001;
    cyc();
    irq_ack = 1'b1;
    look();
    chk("ack_slot0", int'(slot_ack), 3'b001);
    chk("ack_hold", int'(cpu_int), 2'b01);
    cyc();
    irq_ack = 1'b0;
    tile_int_req = '0;
    cyc();
    cyc();
    irq_ack = 1'b1;
    look();
    chk("ack_idle", int'(slot_ack), 3'b000);
    cyc();
    irq_ack = 1'b0;

    // out-of-range pin index still active and blocking
    wr(8'd0, 8'h83);
    tile_int_req = 6'b000101;
    cyc();
    irq_ack = 1'b1;
    look();
    chk("oor_pins", int'(cpu_int), 2'b00);
    chk("oor_ack", int'(slot_ack), 3'b001);
    chk("oor_active", int'(irq_int_active), 1);
    chk("oor_slot", int'(irq_int_slot), 0);
    cyc();
    cfg_rd_en = 1'b1;
    cfg_addr = 8'd0;
    look();
    chk("rd_oor", int'(cfg_rdata), 8'h83);
`ifdef IRQ_ROUTER_STATUS_EN
    cyc();
    cfg_addr = 8'd9;
    look();
    chk("status", int'(cfg_rdata), 8'h80);
`endif

    // reset while active
    cyc();
    rst_n = 1'b0;
    cyc();
    look();
    chk("rst2_ack", int'(slot_ack), 0);
    chk("rst2_active", int'(irq_int_active), 0);
    cyc();
    cfg_addr = 8'd0;
    look();
    chk("rst2_table", int'(cfg_rdata), 0);
    cyc();
    rst_n = 1'b1;
    irq_ack = 1'b0;
    tile_int_req = '0;
    cfg_rd_en = 1'b0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_router.md
Name: irq_router

Overview:
- Routes per-slot tile interrupt requests (maskable INT channels plus one NMI per slot) to CPU INT/NMI pins through a byte-wide routing table written over a simple config bus.
- Level-sensitive, no queuing: exactly one source is active at a time, and NMI wins arbitration over INT.
- CPU-side irq_ack is steered back to the originating slot.
- Sits in the Dock between tile slots and the CPU socket.

Parameters:
- NUM_SLOTS, 3, number of tile slots.
- NUM_CPU_INT, 2, CPU maskable interrupt pins.
- NUM_CPU_NMI, 1, CPU NMI pins.
- NUM_TILE_INT_CH, 2, INT channels per slot.
- CFG_ADDR_WIDTH, 8, config address width.
- SLOT_IDX_WIDTH (local), (NUM_SLOTS<=1)?1:clog2(NUM_SLOTS).

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_clk  in  1  must be driven from clk; unused internally, all logic runs on clk.
- tile_int_req  in  NUM_SLOTS*NUM_TILE_INT_CH  level requests; bit slot*NUM_TILE_INT_CH+ch.
- tile_nmi_req  in  NUM_SLOTS  level NMI requests.
- irq_ack  in  1  CPU acknowledge.
- cpu_int  out  NUM_CPU_INT  active-high INT pins.
- cpu_nmi  out  NUM_CPU_NMI  active-high NMI pins.
- slot_ack  out  NUM_SLOTS  per-slot ack.
- irq_int_active  out  1  active source is an INT.
- irq_int_slot  out  SLOT_IDX_WIDTH  slot of the active INT, 0 when none.
- cfg_wr_en  in  1  table write strobe.
- cfg_rd_en  in  1  table read strobe.
- cfg_addr  in  CFG_ADDR_WIDTH  entry address.
- cfg_wdata  in  8  write data.
- cfg_rdata  out  8  read data.

Behaviour:
- Table layout:
  - Addresses 0..NUM_SLOTS*NUM_TILE_INT_CH-1 are INT entries (slot*NUM_TILE_INT_CH+ch).
  - The next NUM_SLOTS addresses are NMI entries, one per slot.
  - Entry format: bit7 = enable, bits3:0 = CPU pin index. Bits6:4 read back as 0.
- Config writes: take effect at the clk edge sampling cfg_wr_en=1. Writes to unmapped addresses are ignored.
- Config reads: cfg_rdata is combinational, equal to the entry when cfg_rd_en=1 and the address is mapped, else 0.
- Reset (rst_n low at an edge): all entries cleared (disabled, idx 0); active state cleared; all outputs 0.
- Eligibility: a source is eligible when its request is high and its entry is enabled. Disabled requests never affect outputs or block arbitration.
- At each edge:
  - If an active source exists and is still eligible, it is held.
  - Otherwise the active source is replaced in the same edge by the highest-priority eligible source, or none.
  - Priority: any NMI (lowest slot first) before any INT (lowest flattened index first).
  - Handover therefore has zero idle cycles.
- No latching of requests: a request that rises and falls while another source is active is lost.
- Selection latency: one edge from the request being sampled high. The CPU index is latched at selection.
- Output decode (combinational from active state):
  - cpu_int[idx] = 1 for an active INT; cpu_nmi[idx] = 1 for an active NMI.
  - Idx >= pin count drives no pin, but the source still stays active, blocks others and is ackable.
- slot_ack: combinational, one-hot of the active source's slot (INT or NMI) while irq_ack=1; 0 when idle. Ack does not clear the active state.
- irq_int_active / irq_int_slot: reflect the active INT; both 0 when idle or when an NMI is active.
- Disabling the active entry drops the active source at the next edge, and arbitration runs in the same edge.

Optional Feature:
- Macro IRQ_ROUTER_STATUS_EN.
- When defined: a read-only status byte at address NUM_SLOTS*(NUM_TILE_INT_CH+1) returns {active, is_nmi, 2'b0, slot[3:0]}; writes to that address are ignored.
- When undefined: that address is unmapped (reads 0).

Test Plan:
- Reset, then route slot0/ch0 -> INT0 (write 0x80 to addr 0), raise req bit0 -> cpu_int=01 within 2 clocks; drop it -> cpu_int=00.
- Slot0 active; pulse slot1/ch0 (routed to INT1, 0x81 at addr 2) for one cycle; release slot0 -> cpu_int stays 00 (no queuing).
- Route NMI slot1 -> NMI0 (0x80 at addr 7) with slot0/ch0 INT also requested -> cpu_nmi=1, cpu_int=00; drop NMI -> cpu_int=01.
- Slot0/ch0 and slot1/ch0 both requested -> cpu_int=01; drop slot0 -> cpu_int=10.
- Slot0 INT active; irq_ack=1 -> slot_ack=001 combinationally, cpu_int stays 01. irq_ack while idle -> slot_ack=000.
- Route slot0/ch0 to idx 3 (0x83) and raise the request -> cpu_int=00, ack gives slot_ack=001, irq_int_active=1, irq_int_slot=0.
